// File: rtl/mem_pkg.sv
// Shared types and byte helpers for the memory responder and its storage array.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;
  typedef enum logic [1:0] {RD, WR, BAD} op_t;

  // Parity bit that makes the 9-bit group {byte, bit} contain an odd number of ones.
  function automatic logic odd_parity8(input logic [7:0] b);
    return ~(^b);
  endfunction

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU storage-port bundle (re/we/ready handshake). par_inj exists only with MEM_RESPONDER_PARITY_EN.
interface mem_responder_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 28
);
  logic            mem_re;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW/8-1:0] mem_mask;
  logic [DW-1:0]   mem_dout;
  logic            mem_ready;
  logic            mem_rvalid;
  logic            mem_err;
`ifdef MEM_RESPONDER_PARITY_EN
  logic            par_inj;
`endif

  modport master (
    output mem_re, mem_we, mem_addr, mem_din, mem_mask,
`ifdef MEM_RESPONDER_PARITY_EN
    output par_inj,
`endif
    input  mem_dout, mem_ready, mem_rvalid, mem_err
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_din, mem_mask,
`ifdef MEM_RESPONDER_PARITY_EN
    input  par_inj,
`endif
    output mem_dout, mem_ready, mem_rvalid, mem_err
  );
endinterface

// File: rtl/mem_array.sv
// Word storage with one synchronous read/write port; optional odd parity per byte
// under MEM_RESPONDER_PARITY_EN. Read data register holds until the next read.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned NB   = DW / 8,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          wr,
  input  logic          in_range,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdata,
  input  logic [NB-1:0] wmask,
`ifdef MEM_RESPONDER_PARITY_EN
  input  logic          inj,
  output logic          perr,
`endif
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd) begin
      rdata <= in_range ? mem[idx] : '0;
    end
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      for (int unsigned j = 0; j < NB; j++) begin
        mem[idx][8*j +: 8] <= byte_merge(mem[idx][8*j +: 8], wdata[8*j +: 8], wmask[j]);
      end
    end
  end

`ifdef MEM_RESPONDER_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] mism;

  always_comb begin
    mism = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      mism[j] = ~(^{mem[idx][8*j +: 8], par[idx][j]});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      for (int unsigned j = 0; j < NB; j++) begin
        if (wmask[j]) begin
          par[idx][j] <= odd_parity8(wdata[8*j +: 8]) ^ ((j == 0) && inj);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr <= 1'b0;
    end else begin
      perr <= rd && in_range && (|mism);
    end
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// CPU storage-port responder: IDLE/WAIT/XFER handshake FSM in front of mem_array.
// Optional parity checking under MEM_RESPONDER_PARITY_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DW          = 64,
  parameter int unsigned AW          = 28,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned IW = $clog2(DEPTH);

  state_t        state, state_d;
  op_t           op_q, op_d;
  logic [3:0]    cnt, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [NB-1:0] mask_q, mask_d;
  logic          ready_q, ready_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic          in_range;
  logic          arr_rd, arr_wr;
  logic [DW-1:0] rdata;

  assign in_range = addr_q < AW'(DEPTH);
  assign arr_rd   = (state == XFER) && (op_q == RD);
  assign arr_wr   = (state == XFER) && (op_q == WR) && in_range;

`ifdef MEM_RESPONDER_PARITY_EN
  logic inj_q, inj_d, perr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= RD;
      cnt      <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      mask_q   <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef MEM_RESPONDER_PARITY_EN
      inj_q    <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      op_q     <= op_d;
      cnt      <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      mask_q   <= mask_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
`ifdef MEM_RESPONDER_PARITY_EN
      inj_q    <= inj_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    op_d     = op_q;
    cnt_d    = cnt;
    addr_d   = addr_q;
    din_d    = din_q;
    mask_d   = mask_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
`ifdef MEM_RESPONDER_PARITY_EN
    inj_d    = inj_q;
`endif
    unique case (state)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.mem_re || bus.mem_we) begin
          op_d    = (bus.mem_re && bus.mem_we) ? BAD : (bus.mem_we ? WR : RD);
          addr_d  = bus.mem_addr;
          din_d   = bus.mem_din;
          mask_d  = bus.mem_mask;
          ready_d = 1'b0;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : XFER;
`ifdef MEM_RESPONDER_PARITY_EN
          inj_d   = bus.par_inj;
`endif
        end
      end
      WAIT: begin
        ready_d = 1'b0;
        cnt_d   = cnt - 4'd1;
        if (cnt == 4'd1) state_d = XFER;
      end
      XFER: begin
        ready_d = 1'b1;
        state_d = IDLE;
        unique case (op_q)
          RD:      begin rvalid_d = 1'b1; err_d = !in_range; end
          WR:      err_d = !in_range;
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  mem_array #(.DW(DW), .DEPTH(DEPTH)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd       (arr_rd),
    .wr       (arr_wr),
    .in_range (in_range),
    .idx      (addr_q[IW-1:0]),
    .wdata    (din_q),
    .wmask    (mask_q),
`ifdef MEM_RESPONDER_PARITY_EN
    .inj      (inj_q),
    .perr     (perr),
`endif
    .rdata    (rdata)
  );

  assign bus.mem_dout   = rdata;
  assign bus.mem_ready  = ready_q;
  assign bus.mem_rvalid = rvalid_q;
`ifdef MEM_RESPONDER_PARITY_EN
  assign bus.mem_err    = err_q | perr;
`else
  assign bus.mem_err    = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with no wait states, one with three.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        re = 1'b0, we = 1'b0, inj = 1'b0;
  logic [27:0] addr = '0;
  logic [63:0] din = '0;
  logic [7:0]  mask = '0;
  int          checks = 0, errors = 0, cyc = 0;
  int          low, acc_c, ret_c, stray;
  logic        rvs, ers;
  logic [63:0] dv;
  int          a_ret;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.DW(64), .AW(28)) b0 ();
  mem_responder_if #(.DW(64), .AW(28)) b3 ();

  assign b0.mem_re = re & ~sel;  assign b3.mem_re = re & sel;
  assign b0.mem_we = we & ~sel;  assign b3.mem_we = we & sel;
  assign b0.mem_addr = addr;     assign b3.mem_addr = addr;
  assign b0.mem_din = din;       assign b3.mem_din = din;
  assign b0.mem_mask = mask;     assign b3.mem_mask = mask;
`ifdef MEM_RESPONDER_PARITY_EN
  assign b0.par_inj = inj;       assign b3.par_inj = inj;
`endif

  mem_responder #(.DW(64), .AW(28), .DEPTH(256), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  mem_responder #(.DW(64), .AW(28), .DEPTH(256), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  logic rdy, rv, er;
  logic [63:0] dout;
  assign rdy  = sel ? b3.mem_ready  : b0.mem_ready;
  assign rv   = sel ? b3.mem_rvalid : b0.mem_rvalid;
  assign er   = sel ? b3.mem_err    : b0.mem_err;
  assign dout = sel ? b3.mem_dout   : b0.mem_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access; inputs are scrambled after acceptance to prove they are latched.
  task automatic acc(input logic r, input logic w, input logic [27:0] a,
                     input logic [63:0] d, input logic [7:0] m, input logic pi);
    @(negedge clk);
    re = r; we = w; addr = a; din = d; mask = m; inj = pi;
    @(posedge clk); #1;
    acc_c = cyc;
    re = 1'b0; we = 1'b0; addr = '1; din = '1; mask = '1; inj = 1'b0;
    low = 0; stray = 0;
    while (rdy !== 1'b1 && low < 40) begin
      low++;
      if (rv !== 1'b0 || er !== 1'b0) stray++;
      @(posedge clk); #1;
    end
    ret_c = cyc; rvs = rv; ers = er; dv = dout;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", b0.mem_ready, 1'b1);
    chk("rst_rvalid0", b0.mem_rvalid, 1'b0);
    chk("rst_err0", b0.mem_err, 1'b0);
    chk("rst_dout0", b0.mem_dout, 64'h0);
    chk("rst_ready3", b3.mem_ready, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Preload and read back addr 5.
    acc(0, 1, 28'd5, 64'h1E12_1423_0000_0000, 8'hFF, 0);
    chk("wr5_low", low, 1);
    chk("wr5_rvalid", rvs, 1'b0);
    chk("wr5_err", ers, 1'b0);
    acc(1, 0, 28'd5, 64'h0, 8'h00, 0);
    chk("rd5_low", low, 1);
    chk("rd5_stray", stray, 0);
    chk("rd5_rvalid", rvs, 1'b1);
    chk("rd5_err", ers, 1'b0);
    chk("rd5_data", dv, 64'h1E12_1423_0000_0000);
    @(posedge clk); #1;
    chk("rd5_pulse_end", rv, 1'b0);

    // Byte-masked merge.
    acc(0, 1, 28'd3, 64'h1111_1111_1111_1111, 8'hFF, 0);
    acc(0, 1, 28'd3, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0);
    acc(1, 0, 28'd3, 64'h0, 8'h00, 0);
    chk("rd3_merge", dv, 64'h1111_1111_CCCC_DDDD);

    // mask=0 write: handshake only.
    acc(0, 1, 28'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
    chk("wr3_m0_low", low, 1);
    chk("wr3_m0_err", ers, 1'b0);
    acc(1, 0, 28'd3, 64'h0, 8'h00, 0);
    chk("rd3_m0", dv, 64'h1111_1111_CCCC_DDDD);

    // Out of range read and write.
    acc(1, 0, 28'd300, 64'h0, 8'h00, 0);
    chk("rd300_data", dv, 64'h0);
    chk("rd300_err", ers, 1'b1);
    chk("rd300_rvalid", rvs, 1'b1);
    chk("rd300_stray", stray, 0);
    acc(1, 0, 28'd5, 64'h0, 8'h00, 0);
    acc(0, 1, 28'd300, 64'h5555_5555_5555_5555, 8'hFF, 0);
    chk("wr300_err", ers, 1'b1);
    chk("wr300_rvalid", rvs, 1'b0);
    chk("wr300_hold", dv, 64'h1E12_1423_0000_0000);
    @(posedge clk); #1;
    chk("wr300_err_end", er, 1'b0);
    acc(1, 0, 28'd44, 64'h0, 8'h00, 0);
    chk("rd44_alias", dv === 64'h5555_5555_5555_5555, 1'b0);

    // re and we together.
    acc(1, 1, 28'd3, 64'h0, 8'hFF, 0);
    chk("bad_low", low, 1);
    chk("bad_err", ers, 1'b1);
    chk("bad_rvalid", rvs, 1'b0);
    a_ret = 0;
    acc(1, 0, 28'd3, 64'h0, 8'h00, 0);
    chk("bad_unchanged", dv, 64'h1111_1111_CCCC_DDDD);

    // Three wait states, back-to-back write then read.
    sel = 1'b1;
    acc(0, 1, 28'd7, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0);
    chk("w3_wr_low", low, 4);
    chk("w3_wr_stray", stray, 0);
    a_ret = ret_c;
    acc(1, 0, 28'd7, 64'h0, 8'h00, 0);
    chk("w3_b2b_accept", acc_c, a_ret + 1);
    chk("w3_rd_low", low, 4);
    chk("w3_rd_stray", stray, 0);
    chk("w3_rd_rvalid", rvs, 1'b1);
    chk("w3_rd_data", dv, 64'hDEAD_BEEF_0123_4567);
    sel = 1'b0;

    // Reset on the XFER edge of a write.
    acc(0, 1, 28'd9, 64'h9999_0000_9999_0000, 8'hFF, 0);
    @(negedge clk);
    we = 1'b1; addr = 28'd9; din = 64'h0123_0123_0123_0123; mask = 8'hFF;
    @(posedge clk); #1;
    we = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstx_ready", rdy, 1'b1);
    chk("rstx_rvalid", rv, 1'b0);
    chk("rstx_err", er, 1'b0);
    chk("rstx_dout", dout, 64'h0);
    @(negedge clk); rst = 1'b0;
    acc(1, 0, 28'd9, 64'h0, 8'h00, 0);
    chk("rstx_kept", dv, 64'h9999_0000_9999_0000);

`ifdef MEM_RESPONDER_PARITY_EN
    acc(0, 1, 28'd2, 64'h0F0F_F0F0_1234_5678, 8'hFF, 1);
    chk("par_wr_err", ers, 1'b0);
    acc(1, 0, 28'd2, 64'h0, 8'h00, 0);
    chk("par_bad_err", ers, 1'b1);
    chk("par_bad_rvalid", rvs, 1'b1);
    chk("par_bad_data", dv, 64'h0F0F_F0F0_1234_5678);
    acc(0, 1, 28'd2, 64'h0F0F_F0F0_1234_5678, 8'hFF, 0);
    acc(1, 0, 28'd2, 64'h0, 8'h00, 0);
    chk("par_clean_err", ers, 1'b0);
    chk("par_clean_data", dv, 64'h0F0F_F0F0_1234_5678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
